// File: rtl/kf8259_in_service_n.sv
// Parametrised in-service register for the KF8259: ISR, EOI handling, priority rotation, nest depth.
// Optional rotation logic is built when KF8259_ISR_ROTATE_EN is defined; otherwise priority is fixed.
module kf8259_in_service_n #(
   parameter int unsigned LEVELS  = 8,
   parameter int unsigned PRIO_W  = $clog2(LEVELS),
   parameter int unsigned DEPTH_W = $clog2(LEVELS + 1)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [LEVELS-1:0]   i_special_mask,
   input  logic                i_ack_valid,
   input  logic [LEVELS-1:0]   i_ack_vector,
   input  logic                i_auto_eoi,
   input  logic                i_rotate_on_aeoi,
   input  logic                i_eoi_valid,
   input  logic [1:0]          i_eoi_cmd,
   input  logic [PRIO_W-1:0]   i_eoi_level,
   input  logic                i_set_prio_valid,
   input  logic [PRIO_W-1:0]   i_set_prio_level,
   output logic [LEVELS-1:0]   o_in_service_register,
   output logic [LEVELS-1:0]   o_highest_level_in_service,
   output logic [PRIO_W-1:0]   o_lowest_priority,
   output logic [DEPTH_W-1:0]  o_nest_depth,
   output logic                o_eoi_error
);

   logic [LEVELS-1:0]  r_isr;
   logic [LEVELS-1:0]  r_hlis;
   logic [PRIO_W-1:0]  r_lowest;
   logic [DEPTH_W-1:0] r_depth;
   logic               r_eoi_error;

   logic [LEVELS-1:0]  w_spec_mask;
   logic               w_level_ok;
   logic [LEVELS-1:0]  w_clear_mask;
   logic               w_eoi_invalid;
   logic               w_eoi_ok;
   logic [LEVELS-1:0]  w_clear;
   logic [LEVELS-1:0]  w_set;
   logic [LEVELS-1:0]  w_next_isr;
   logic [PRIO_W-1:0]  w_next_lowest;
   logic [LEVELS-1:0]  w_next_hlis;
   logic [DEPTH_W-1:0] w_next_depth;

   // One-hot of the highest-priority set bit, scanning upward from lowest+1 with wrap-around.
   function automatic logic [LEVELS-1:0] f_resolve(input logic [LEVELS-1:0] vec,
                                                    input logic [PRIO_W-1:0] low);
      logic [LEVELS-1:0] res;
      logic [LEVELS-1:0] bit_mask;
      int unsigned       idx;
      res = '0;
      for (int k = int'(LEVELS) - 1; k >= 0; k--) begin
         idx      = (32'(low) + 32'(k) + 32'd1) % LEVELS;
         bit_mask = LEVELS'(1) << idx;
         if ((vec & bit_mask) != '0) res = bit_mask;
      end
      return res;
   endfunction

   function automatic logic [PRIO_W-1:0] f_index(input logic [LEVELS-1:0] oh);
      logic [PRIO_W-1:0] r;
      r = '0;
      for (int i = 0; i < int'(LEVELS); i++) begin
         if (oh[i]) r = r | PRIO_W'(i);
      end
      return r;
   endfunction

   function automatic logic [DEPTH_W-1:0] f_popcount(input logic [LEVELS-1:0] vec);
      logic [DEPTH_W-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < int'(LEVELS); i++) begin
         cnt = cnt + DEPTH_W'(vec[i]);
      end
      return cnt;
   endfunction

   // EOI validation and next ISR; an acknowledge of the same bit wins over its clear.
   always_comb begin
      w_spec_mask   = LEVELS'(1) << i_eoi_level;
      w_level_ok    = 32'(i_eoi_level) < LEVELS;
      w_clear_mask  = i_eoi_cmd[0] ? w_spec_mask : r_hlis;
      w_eoi_invalid = i_eoi_cmd[0] ? (!w_level_ok || ((r_isr & w_spec_mask) == '0))
                                   : (r_hlis == '0);
      w_eoi_ok      = i_eoi_valid && !w_eoi_invalid;
      w_clear       = w_eoi_ok ? w_clear_mask : '0;
      w_set         = (i_ack_valid && !i_auto_eoi) ? i_ack_vector : '0;
      w_next_isr    = (r_isr & ~w_clear) | w_set;
   end

`ifdef KF8259_ISR_ROTATE_EN
   logic [PRIO_W-1:0] w_cleared_level;

   // Later assignments win: set_prio over EOI rotate over AEOI rotate.
   always_comb begin
      w_cleared_level = i_eoi_cmd[0] ? i_eoi_level : f_index(r_hlis);
      w_next_lowest   = r_lowest;
      if (i_ack_valid && i_auto_eoi && i_rotate_on_aeoi && (i_ack_vector != '0))
         w_next_lowest = f_index(f_resolve(i_ack_vector, r_lowest));
      if (w_eoi_ok && i_eoi_cmd[1])
         w_next_lowest = w_cleared_level;
      if (i_set_prio_valid && (32'(i_set_prio_level) < LEVELS))
         w_next_lowest = i_set_prio_level;
   end
`else
   logic w_unused;

   assign w_unused      = ^{i_rotate_on_aeoi, i_set_prio_valid, i_set_prio_level, i_eoi_cmd[1]};
   assign w_next_lowest = PRIO_W'(LEVELS - 1);
`endif

   always_comb begin
      w_next_hlis  = f_resolve(w_next_isr & ~i_special_mask, w_next_lowest);
      w_next_depth = f_popcount(w_next_isr);
   end

   always_ff @(negedge clock or posedge reset) begin
      if (reset) begin
         r_isr       <= '0;
         r_hlis      <= '0;
         r_lowest    <= PRIO_W'(LEVELS - 1);
         r_depth     <= '0;
         r_eoi_error <= 1'b0;
      end else begin
         r_isr       <= w_next_isr;
         r_hlis      <= w_next_hlis;
         r_lowest    <= w_next_lowest;
         r_depth     <= w_next_depth;
         r_eoi_error <= i_eoi_valid && w_eoi_invalid;
      end
   end

   assign o_in_service_register      = r_isr;
   assign o_highest_level_in_service = r_hlis;
   assign o_lowest_priority          = r_lowest;
   assign o_nest_depth               = r_depth;
   assign o_eoi_error                = r_eoi_error;

endmodule

// File: tb/tb_kf8259_in_service_n.sv
// Scoreboard bench for kf8259_in_service_n (LEVELS=8); expectations adapt to KF8259_ISR_ROTATE_EN.
module tb_kf8259_in_service_n;

`ifdef KF8259_ISR_ROTATE_EN
   localparam bit ROT = 1'b1;
`else
   localparam bit ROT = 1'b0;
`endif

   typedef struct {
      logic       rst;
      logic       ackv;
      logic [7:0] ack;
      logic       aeoi;
      logic       raeoi;
      logic       eoiv;
      logic [1:0] cmd;
      logic [2:0] lvl;
      logic       spv;
      logic [2:0] spl;
      logic [7:0] smask;
   } stim_t;

   typedef struct {
      int         id;
      logic [7:0] isr;
      logic [7:0] hl;
      logic [2:0] low;
      logic [3:0] dep;
      logic       err;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] special_mask;
   logic       ack_valid;
   logic [7:0] ack_vector;
   logic       auto_eoi;
   logic       rotate_on_aeoi;
   logic       eoi_valid;
   logic [1:0] eoi_cmd;
   logic [2:0] eoi_level;
   logic       set_prio_valid;
   logic [2:0] set_prio_level;
   logic [7:0] isr_o;
   logic [7:0] hl_o;
   logic [2:0] low_o;
   logic [3:0] dep_o;
   logic       err_o;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   step_id = 0;

   kf8259_in_service_n #(.LEVELS(8)) dut (
      .clock                      (clock),
      .reset                      (reset),
      .i_special_mask             (special_mask),
      .i_ack_valid                (ack_valid),
      .i_ack_vector               (ack_vector),
      .i_auto_eoi                 (auto_eoi),
      .i_rotate_on_aeoi           (rotate_on_aeoi),
      .i_eoi_valid                (eoi_valid),
      .i_eoi_cmd                  (eoi_cmd),
      .i_eoi_level                (eoi_level),
      .i_set_prio_valid           (set_prio_valid),
      .i_set_prio_level           (set_prio_level),
      .o_in_service_register      (isr_o),
      .o_highest_level_in_service (hl_o),
      .o_lowest_priority          (low_o),
      .o_nest_depth               (dep_o),
      .o_eoi_error                (err_o)
   );

   always #5 clock = ~clock;

   function automatic stim_t f_idle();
      stim_t s;
      s = '{rst:1'b0, ackv:1'b0, ack:8'h00, aeoi:1'b0, raeoi:1'b0, eoiv:1'b0,
            cmd:2'b00, lvl:3'd0, spv:1'b0, spl:3'd0, smask:8'h00};
      return s;
   endfunction

   function automatic stim_t f_ack(input logic [7:0] v);
      stim_t s;
      s = f_idle();
      s.ackv = 1'b1;
      s.ack  = v;
      return s;
   endfunction

   function automatic stim_t f_eoi(input logic [1:0] cmd, input logic [2:0] lvl);
      stim_t s;
      s = f_idle();
      s.eoiv = 1'b1;
      s.cmd  = cmd;
      s.lvl  = lvl;
      return s;
   endfunction

   function automatic stim_t f_sp(input logic [2:0] l);
      stim_t s;
      s = f_idle();
      s.spv = 1'b1;
      s.spl = l;
      return s;
   endfunction

   // Drive one falling-edge worth of inputs and queue the state expected after that edge.
   task automatic step(input stim_t s, input logic [7:0] isr, input logic [7:0] hl,
                       input logic [2:0] low, input logic [3:0] dep, input logic err);
      exp_t e;
      @(posedge clock);
      #1;
      reset          = s.rst;
      ack_valid      = s.ackv;
      ack_vector     = s.ack;
      auto_eoi       = s.aeoi;
      rotate_on_aeoi = s.raeoi;
      eoi_valid      = s.eoiv;
      eoi_cmd        = s.cmd;
      eoi_level      = s.lvl;
      set_prio_valid = s.spv;
      set_prio_level = s.spl;
      special_mask   = s.smask;
      step_id++;
      e = '{id:step_id, isr:isr, hl:hl, low:low, dep:dep, err:err};
      exp_q.push_back(e);
   endtask

   task automatic check(input string name, input int id, input logic [31:0] act,
                        input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, id, act, expv);
      end
   endtask

   // Monitor: outputs settle on the falling edge, compared on the following rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("isr",    e.id, 32'(isr_o), 32'(e.isr));
            check("high",   e.id, 32'(hl_o),  32'(e.hl));
            check("lowest", e.id, 32'(low_o), 32'(e.low));
            check("depth",  e.id, 32'(dep_o), 32'(e.dep));
            check("eoierr", e.id, 32'(err_o), 32'(e.err));
         end
      end
   end

   initial begin
      stim_t s;
      reset = 1'b1;
      {special_mask, ack_valid, ack_vector, auto_eoi, rotate_on_aeoi} = '0;
      {eoi_valid, eoi_cmd, eoi_level, set_prio_valid, set_prio_level} = '0;

      s = f_idle(); s.rst = 1'b1;
      step(s, 8'h00, 8'h00, 3'd7, 4'd0, 1'b0);
      step(f_idle(), 8'h00, 8'h00, 3'd7, 4'd0, 1'b0);

      // Nesting and non-specific EOI
      step(f_ack(8'h04), 8'h04, 8'h04, 3'd7, 4'd1, 1'b0);
      step(f_ack(8'h01), 8'h05, 8'h01, 3'd7, 4'd2, 1'b0);
      step(f_eoi(2'b00, 3'd0), 8'h04, 8'h04, 3'd7, 4'd1, 1'b0);
      step(f_eoi(2'b01, 3'd2), 8'h00, 8'h00, 3'd7, 4'd0, 1'b0);

      // Rotating non-specific EOI
      step(f_ack(8'h08), 8'h08, 8'h08, 3'd7, 4'd1, 1'b0);
      step(f_eoi(2'b10, 3'd0), 8'h00, 8'h00, ROT ? 3'd3 : 3'd7, 4'd0, 1'b0);
      step(f_ack(8'h04), 8'h04, 8'h04, ROT ? 3'd3 : 3'd7, 4'd1, 1'b0);
      step(f_ack(8'h10), 8'h14, ROT ? 8'h10 : 8'h04, ROT ? 3'd3 : 3'd7, 4'd2, 1'b0);
      step(f_eoi(2'b01, 3'd4), 8'h04, 8'h04, ROT ? 3'd3 : 3'd7, 4'd1, 1'b0);
      step(f_eoi(2'b01, 3'd2), 8'h00, 8'h00, ROT ? 3'd3 : 3'd7, 4'd0, 1'b0);
      step(f_sp(3'd7), 8'h00, 8'h00, 3'd7, 4'd0, 1'b0);

      // Special mask
      step(f_ack(8'h04), 8'h04, 8'h04, 3'd7, 4'd1, 1'b0);
      s = f_ack(8'h01); s.smask = 8'h01;
      step(s, 8'h05, 8'h04, 3'd7, 4'd2, 1'b0);
      s = f_eoi(2'b00, 3'd0); s.smask = 8'h01;
      step(s, 8'h01, 8'h00, 3'd7, 4'd1, 1'b0);

      // Invalid EOIs pulse eoi_error for one cycle without touching state
      step(f_ack(8'h04), 8'h05, 8'h01, 3'd7, 4'd2, 1'b0);
      step(f_eoi(2'b01, 3'd6), 8'h05, 8'h01, 3'd7, 4'd2, 1'b1);
      step(f_idle(), 8'h05, 8'h01, 3'd7, 4'd2, 1'b0);
      step(f_eoi(2'b01, 3'd0), 8'h04, 8'h04, 3'd7, 4'd1, 1'b0);
      step(f_eoi(2'b01, 3'd2), 8'h00, 8'h00, 3'd7, 4'd0, 1'b0);
      step(f_eoi(2'b10, 3'd0), 8'h00, 8'h00, 3'd7, 4'd0, 1'b1);
      step(f_idle(), 8'h00, 8'h00, 3'd7, 4'd0, 1'b0);

      // Simultaneous set/clear and set_prio over EOI rotate
      step(f_ack(8'h02), 8'h02, 8'h02, 3'd7, 4'd1, 1'b0);
      s = f_eoi(2'b01, 3'd1); s.ackv = 1'b1; s.ack = 8'h02;
      step(s, 8'h02, 8'h02, 3'd7, 4'd1, 1'b0);
      step(f_ack(8'h20), 8'h22, 8'h02, 3'd7, 4'd2, 1'b0);
      s = f_eoi(2'b11, 3'd5); s.spv = 1'b1; s.spl = 3'd2;
      step(s, 8'h02, 8'h02, ROT ? 3'd2 : 3'd7, 4'd1, 1'b0);
      step(f_eoi(2'b11, 3'd1), 8'h00, 8'h00, ROT ? 3'd1 : 3'd7, 4'd0, 1'b0);
      step(f_ack(8'h01), 8'h01, 8'h01, ROT ? 3'd1 : 3'd7, 4'd1, 1'b0);
      step(f_ack(8'h04), 8'h05, ROT ? 8'h04 : 8'h01, ROT ? 3'd1 : 3'd7, 4'd2, 1'b0);
      step(f_eoi(2'b01, 3'd0), 8'h04, 8'h04, ROT ? 3'd1 : 3'd7, 4'd1, 1'b0);
      step(f_eoi(2'b01, 3'd2), 8'h00, 8'h00, ROT ? 3'd1 : 3'd7, 4'd0, 1'b0);
      step(f_sp(3'd7), 8'h00, 8'h00, 3'd7, 4'd0, 1'b0);

      // Auto-EOI with rotation, single and multi-hot
      s = f_ack(8'h20); s.aeoi = 1'b1; s.raeoi = 1'b1;
      step(s, 8'h00, 8'h00, ROT ? 3'd5 : 3'd7, 4'd0, 1'b0);
      s = f_ack(8'h24); s.aeoi = 1'b1; s.raeoi = 1'b1;
      step(s, 8'h00, 8'h00, ROT ? 3'd2 : 3'd7, 4'd0, 1'b0);

      // Mid-operation reset, then fresh start with back-to-back EOIs
      step(f_ack(8'h81), 8'h81, ROT ? 8'h80 : 8'h01, ROT ? 3'd2 : 3'd7, 4'd2, 1'b0);
      s = f_idle(); s.rst = 1'b1;
      step(s, 8'h00, 8'h00, 3'd7, 4'd0, 1'b0);
      step(f_ack(8'h02), 8'h02, 8'h02, 3'd7, 4'd1, 1'b0);
      step(f_ack(8'h08), 8'h0A, 8'h02, 3'd7, 4'd2, 1'b0);
      step(f_eoi(2'b00, 3'd0), 8'h08, 8'h08, 3'd7, 4'd1, 1'b0);
      step(f_eoi(2'b00, 3'd0), 8'h00, 8'h00, 3'd7, 4'd0, 1'b0);
      step(f_idle(), 8'h00, 8'h00, 3'd7, 4'd0, 1'b0);

      repeat (4) @(posedge clock);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/kf8259_in_service_n.md
# kf8259_in_service_n

Parametrised in-service tracker for the KF8259 interrupt controller family. It generalises the fixed 8-level in-service register to `LEVELS` levels and owns the rotation state. It executes all EOI command types (non-specific, specific, and their rotating forms), auto-EOI with optional rotation, and specific priority set, and it reports nesting depth and EOI misuse. It sits between the acknowledge sequencer and the priority resolver, which consumes `highest_level_in_service` and `lowest_priority`.

## Interface
- `LEVELS`, default 8: number of interrupt levels, 2..32.
- `PRIO_W`, default `$clog2(LEVELS)`: level index width.
- `DEPTH_W`, default `$clog2(LEVELS+1)`: nest counter width.
- `clock` in 1: state updates on falling edge.
- `reset` in 1: asynchronous, active-high.
- `special_mask` in LEVELS: levels excluded from highest-in-service resolution.
- `ack_valid` in 1: interrupt acknowledge strobe.
- `ack_vector` in LEVELS: level(s) being acknowledged; one-hot expected.
- `auto_eoi` in 1: auto-EOI mode.
- `rotate_on_aeoi` in 1: rotate priority on auto-EOI acknowledge.
- `eoi_valid` in 1: EOI command strobe.
- `eoi_cmd` in 2: EOI command type.
  - 00: non-specific.
  - 01: specific.
  - 10: rotate non-specific.
  - 11: rotate specific.
- `eoi_level` in PRIO_W: target level for specific commands.
- `set_prio_valid` in 1: set lowest priority without EOI.
- `set_prio_level` in PRIO_W: new lowest-priority level.
- `in_service_register` out LEVELS: ISR bits.
- `highest_level_in_service` out LEVELS: one-hot highest unmasked ISR level, or 0.
- `lowest_priority` out PRIO_W: current bottom-priority level.
- `nest_depth` out DEPTH_W: population count of the ISR.
- `eoi_error` out 1: one-cycle pulse on an invalid EOI.

## Operation
- **Priority order.** Level `(lowest_priority+1) mod LEVELS` has the highest priority, then ascending with wrap-around. `lowest_priority` has the lowest priority.
- **Clear mask (EOI).**
  - Non-specific forms clear the bit currently shown in `highest_level_in_service`.
  - Specific forms clear bit `eoi_level`.
- **Set mask (acknowledge).** `ack_vector` when `ack_valid` and not `auto_eoi`; otherwise 0.
- **Next ISR.** `next_isr = (isr & ~clear) | set`. When set and clear target the same bit, set wins.
- **Invalid EOI.** Either of the following pulses `eoi_error` and changes no other state, including rotation:
  - a non-specific form while `highest_level_in_service == 0`;
  - a specific form whose ISR bit is 0, or whose `eoi_level >= LEVELS`.
- **Rotation.**
  - A valid rotating EOI sets `lowest_priority` to the cleared level.
  - An `ack_valid` with `auto_eoi` and `rotate_on_aeoi` sets `lowest_priority` to the highest-priority bit of `ack_vector`, evaluated under the current order.
  - `set_prio_valid` loads `set_prio_level`; a value `>= LEVELS` is ignored.
  - Precedence when several occur in the same cycle: `set_prio` > EOI rotate > AEOI rotate.
- **Acknowledge vector.** A multi-hot `ack_vector` sets all its bits. An all-zero vector is a no-op.
- **Highest level in service.** Computed from `next_isr & ~special_mask` under the next-cycle priority order: rotate right by `(next_lowest+1) mod LEVELS`, resolve the lowest index, rotate back. The result is registered.
- **Nest depth.** `nest_depth = popcount(next_isr)`, registered; it never exceeds LEVELS.

## Timing
- All inputs are sampled on the falling edge of `clock`. All outputs are registered and update on that same edge, so latency is 1 edge from strobe to output.
- A non-specific EOI uses the registered `highest_level_in_service` from before the edge. Back-to-back EOIs on consecutive edges each clear the next level.
- `eoi_error` is high for exactly one cycle per invalid EOI.
- Reset values: `in_service_register`=0, `highest_level_in_service`=0, `lowest_priority`=LEVELS-1, `nest_depth`=0, `eoi_error`=0.
- Reset asserted mid-operation clears all state immediately. The first edge after deassertion behaves as a fresh start.

## Configuration
- **`KF8259_ISR_ROTATE_EN` defined:** rotation logic as described above.
- **`KF8259_ISR_ROTATE_EN` undefined:**
  - `lowest_priority` is constant LEVELS-1, giving fixed priority with level 0 highest.
  - Rotating EOI forms behave as their non-rotating counterparts.
  - `set_prio_valid` and `rotate_on_aeoi` are ignored.
  - All other behaviour is identical.

## Test plan
All scenarios use LEVELS=8 with rotation enabled unless noted.
1. **Reset and nesting.** Reset, then ack 0x04, then ack 0x01 -> ISR 0x05, highest 0x01, depth 2. Non-specific EOI -> ISR 0x04, highest 0x04, depth 1.
2. **Rotating EOI.** ISR 0x08, rotate non-specific EOI -> ISR 0, `lowest_priority`=3. Ack 0x04, then ack 0x10 -> highest 0x10.
3. **Special mask.** `special_mask`=0x01 with ISR 0x05 -> highest 0x04. Non-specific EOI -> ISR 0x01, highest 0.
4. **Invalid specific EOI.** Specific EOI level 6 with ISR 0x05 -> ISR unchanged, `eoi_error` high for one cycle. Non-specific EOI with ISR 0 -> `eoi_error` pulse, no change.
5. **Simultaneous events.**
   - Ack 0x02 with specific EOI level 1 and ISR 0x02 -> ISR stays 0x02.
   - `set_prio` level 2 with rotate specific EOI level 5 -> `lowest_priority`=2, ISR bit 5 cleared.
6. **AEOI rotation.** `auto_eoi`=1, `rotate_on_aeoi`=1, ack 0x20 -> ISR stays 0, `lowest_priority`=5. Repeat without the macro -> `lowest_priority` stays 7.
